// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the control unit and mult_div_unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic start;
  logic div_mult_ctrl;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic busy;
  logic done;
  logic div0;
  modport master (output start, div_mult_ctrl, a_in, b_in, input hi_out, lo_out, busy, done, div0);
  modport slave (input start, div_mult_ctrl, a_in, b_in, output hi_out, lo_out, busy, done, div0);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed Booth multiply / restoring divide, one bit per clock.
// Define MULTDIV_EARLY_TERM_EN to finish zero-operand MULT/DIV in one step.
module mult_div_unit #(parameter int WIDTH = 32) (
  input  logic clk,
  input  logic reset_in,
  mult_div_unit_if.slave s
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] upper;
  logic [WIDTH-1:0] lower, m_reg, hi_q, lo_q;
  logic q1, is_div, neg_q, neg_r, div0_q;
  logic [WIDTH:0] sel, shifted, diff, up_n;
  logic [WIDTH-1:0] lo_n, res_hi, res_lo, abs_a, abs_b;
  logic q1_n, ok, last, div0_hit, early;
  assign abs_a = s.a_in[WIDTH-1] ? -s.a_in : s.a_in;
  assign abs_b = s.b_in[WIDTH-1] ? -s.b_in : s.b_in;
  assign div0_hit = s.div_mult_ctrl && s.b_in == '0;
`ifdef MULTDIV_EARLY_TERM_EN
  assign early = s.div_mult_ctrl ? (s.a_in == '0 && s.b_in != '0) : (s.a_in == '0 || s.b_in == '0);
`else
  assign early = 1'b0;
`endif
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    sel = {lower[0], q1} == 2'b01 ? upper + {m_reg[WIDTH-1], m_reg} :
          {lower[0], q1} == 2'b10 ? upper - {m_reg[WIDTH-1], m_reg} : upper;
    shifted = {upper[WIDTH-1:0], lower[WIDTH-1]};
    diff = shifted - {1'b0, m_reg};
    ok = !diff[WIDTH];
    up_n = is_div ? (ok ? diff : shifted) : {sel[WIDTH], sel[WIDTH:1]};
    lo_n = is_div ? {lower[WIDTH-2:0], ok} : {sel[0], lower[WIDTH-1:1]};
    q1_n = is_div ? 1'b0 : lower[0];
    // Signs are restored on the last iteration so the result lands with no extra cycle
    res_lo = is_div && neg_q ? -lo_n : lo_n;
    res_hi = is_div && neg_r ? -up_n[WIDTH-1:0] : up_n[WIDTH-1:0];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = s.start ? ((div0_hit || early) ? DONE : RUN) : IDLE;
      RUN: state_n = last ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset_in)
    if (reset_in) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset_in)
    if (reset_in) begin
      cnt <= '0;
      upper <= '0;
      lower <= '0;
      m_reg <= '0;
      q1 <= 1'b0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == IDLE && s.start) begin
      cnt <= '0;
      upper <= '0;
      q1 <= 1'b0;
      is_div <= s.div_mult_ctrl;
      div0_q <= div0_hit;
      lower <= s.div_mult_ctrl ? abs_a : s.b_in;
      m_reg <= s.div_mult_ctrl ? abs_b : s.a_in;
      neg_q <= s.a_in[WIDTH-1] ^ s.b_in[WIDTH-1];
      neg_r <= s.a_in[WIDTH-1];
      if (early && !div0_hit) begin
        hi_q <= '0;
        lo_q <= '0;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      upper <= up_n;
      lower <= lo_n;
      q1 <= q1_n;
      if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  assign s.hi_out = hi_q;
  assign s.lo_out = lo_q;
  assign s.busy = state != IDLE;
  assign s.done = state == DONE;
  assign s.div0 = state == DONE && div0_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of latency, results, div0, ignored starts and reset abort.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset_in = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  mult_div_unit_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset_in(reset_in), .s(bus.slave));
  always #5 clk = ~clk;
`ifdef MULTDIV_EARLY_TERM_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif
  task automatic run_op(input logic ctrl, input logic [31:0] a, input logic [31:0] b, output int lat, output int busy_low);
    @(negedge clk);
    bus.start = 1'b1;
    bus.div_mult_ctrl = ctrl;
    bus.a_in = a;
    bus.b_in = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in = 32'hDEAD_BEEF;
    bus.b_in = 32'h0;
    lat = 1;
    busy_low = 0;
    while (!bus.done && lat < 50) begin
      if (!bus.busy) busy_low++;
      @(negedge clk);
      lat++;
    end
    if (!bus.busy) busy_low++;
  endtask
  task automatic test_reset();
    #1;
    if ({bus.hi_out, bus.lo_out} !== 64'h0) begin $display("FAIL reset_hilo got %h want 0", {bus.hi_out, bus.lo_out}); n_fail++; end
    n_tests++;
    if ({bus.busy, bus.done, bus.div0} !== 3'b000) begin $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.div0}); n_fail++; end
    n_tests++;
    @(negedge clk);
    @(negedge clk);
    reset_in = 1'b0;
  endtask
  task automatic test_mult();
    int lat, bl;
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, bl);
    if (lat !== 33) begin $display("FAIL mult_latency got %0d want 33", lat); n_fail++; end
    n_tests++;
    if (bl !== 0) begin $display("FAIL mult_busy low_cycles got %0d want 0", bl); n_fail++; end
    n_tests++;
    if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFF_FFFF_FFEB) begin $display("FAIL mult_neg got %h want FFFFFFFFFFFFFFEB", {bus.hi_out, bus.lo_out}); n_fail++; end
    n_tests++;
    if (bus.div0 !== 1'b0) begin $display("FAIL mult_div0 got %b want 0", bus.div0); n_fail++; end
    n_tests++;
    @(negedge clk);
    if ({bus.busy, bus.done} !== 2'b00) begin $display("FAIL mult_after got %b want 00", {bus.busy, bus.done}); n_fail++; end
    n_tests++;
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, bl);
    if ({bus.hi_out, bus.lo_out} !== 64'h4000_0000_0000_0000) begin $display("FAIL mult_minsq got %h want 4000000000000000", {bus.hi_out, bus.lo_out}); n_fail++; end
    n_tests++;
  endtask
  task automatic test_div();
    int lat, bl;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bl);
    if (lat !== 33) begin $display("FAIL div_latency got %0d want 33", lat); n_fail++; end
    n_tests++;
    if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFF_FFFF_FFFD) begin $display("FAIL div_neg got %h want FFFFFFFFFFFFFFFD", {bus.hi_out, bus.lo_out}); n_fail++; end
    n_tests++;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bl);
    if ({bus.hi_out, bus.lo_out, bus.div0} !== {64'h0000_0000_8000_0000, 1'b0}) begin $display("FAIL div_overflow got %h div0=%b want 0000000080000000 div0=0", {bus.hi_out, bus.lo_out}, bus.div0); n_fail++; end
    n_tests++;
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, bl);
    if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFE_FFFF_FFF2) begin $display("FAIL div_negrem got %h want FFFFFFFEFFFFFFF2", {bus.hi_out, bus.lo_out}); n_fail++; end
    n_tests++;
  endtask
  task automatic test_div0();
    int lat, bl;
    run_op(1'b1, 32'h451, 32'h20, lat, bl);
    if ({bus.hi_out, bus.lo_out} !== 64'h0000_0011_0000_0022) begin $display("FAIL div_setup got %h want 0000001100000022", {bus.hi_out, bus.lo_out}); n_fail++; end
    n_tests++;
    run_op(1'b1, 32'd5, 32'd0, lat, bl);
    if (lat !== 1) begin $display("FAIL div0_latency got %0d want 1", lat); n_fail++; end
    n_tests++;
    if ({bus.done, bus.div0} !== 2'b11) begin $display("FAIL div0_flags got %b want 11", {bus.done, bus.div0}); n_fail++; end
    n_tests++;
    if ({bus.hi_out, bus.lo_out} !== 64'h0000_0011_0000_0022) begin $display("FAIL div0_hold got %h want 0000001100000022", {bus.hi_out, bus.lo_out}); n_fail++; end
    n_tests++;
    @(negedge clk);
    if ({bus.busy, bus.done, bus.div0} !== 3'b000) begin $display("FAIL div0_idle got %b want 000", {bus.busy, bus.done, bus.div0}); n_fail++; end
    n_tests++;
  endtask
  task automatic test_ignore_start();
    int cyc, dones, done_cyc;
    logic [63:0] res;
    @(negedge clk);
    bus.start = 1'b1;
    bus.div_mult_ctrl = 1'b0;
    bus.a_in = 32'd3;
    bus.b_in = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    done_cyc = 0;
    res = '0;
    for (cyc = 1; cyc < 45; cyc++) begin
      if (bus.done) begin dones++; done_cyc = cyc; res = {bus.hi_out, bus.lo_out}; end
      bus.start = (cyc == 4) || bus.done;
      bus.div_mult_ctrl = 1'b1;
      bus.a_in = 32'd100;
      bus.b_in = 32'd9;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (dones !== 1 || done_cyc !== 33) begin $display("FAIL ignore_done count=%0d at=%0d want 1 at 33", dones, done_cyc); n_fail++; end
    n_tests++;
    if (res !== 64'd12) begin $display("FAIL ignore_result got %h want 000000000000000C", res); n_fail++; end
    n_tests++;
    if (bus.busy !== 1'b0) begin $display("FAIL ignore_requeue busy got %b want 0", bus.busy); n_fail++; end
    n_tests++;
  endtask
  task automatic test_reset_abort();
    int lat, bl, dones;
    @(negedge clk);
    bus.start = 1'b1;
    bus.div_mult_ctrl = 1'b1;
    bus.a_in = 32'd100;
    bus.b_in = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_in = 1'b1;
    #1;
    if ({bus.hi_out, bus.lo_out, bus.busy, bus.done, bus.div0} !== 67'h0) begin $display("FAIL abort_outputs got %h want 0", {bus.hi_out, bus.lo_out, bus.busy, bus.done, bus.div0}); n_fail++; end
    n_tests++;
    @(negedge clk);
    @(negedge clk);
    reset_in = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    if (dones !== 0) begin $display("FAIL abort_activity got %0d cycles want 0", dones); n_fail++; end
    n_tests++;
    run_op(1'b1, 32'd100, 32'd7, lat, bl);
    if (lat !== 33 || {bus.hi_out, bus.lo_out} !== 64'h0000_0002_0000_000E) begin $display("FAIL abort_rerun lat=%0d got %h want lat=33 000000020000000E", lat, {bus.hi_out, bus.lo_out}); n_fail++; end
    n_tests++;
  endtask
  task automatic test_zero_operand();
    int lat, bl;
    run_op(1'b0, 32'd0, 32'h1234, lat, bl);
    if (lat !== ZERO_LAT) begin $display("FAIL zero_latency got %0d want %0d", lat, ZERO_LAT); n_fail++; end
    n_tests++;
    if ({bus.hi_out, bus.lo_out, bus.div0} !== 65'h0) begin $display("FAIL zero_result got %h div0=%b want 0 div0=0", {bus.hi_out, bus.lo_out}, bus.div0); n_fail++; end
    n_tests++;
    run_op(1'b1, 32'd9, 32'd4, lat, bl);
    run_op(1'b1, 32'd0, 32'd5, lat, bl);
    if (lat !== ZERO_LAT || {bus.hi_out, bus.lo_out} !== 64'h0) begin $display("FAIL zero_div lat=%0d got %h want lat=%0d 0", lat, {bus.hi_out, bus.lo_out}, ZERO_LAT); n_fail++; end
    n_tests++;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.div_mult_ctrl = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_ignore_start();
    test_reset_abort();
    test_zero_operand();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
